// File: rtl/mem_access_seq.sv
`default_nettype none
// mem_access_seq: splits one vector load/store into LANES consecutive word accesses on
// the MEM-stage data port and returns one response per request. Rev 1.0
module mem_access_seq #(
    parameter int LANES = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [AW-1:0]       req_base,
    input  logic [LANES*DW-1:0] req_wdata,
    output logic                mem_sel,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [LANES*DW-1:0] rsp_rdata
);

    localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [KW-1:0] LAST = KW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state;
    logic [KW-1:0]         k;
    logic [AW-1:0]         base;
    logic                  wr;
    logic [LANES*DW-1:0]   wbuf;
    logic [KW-1:0]         k_next;
    logic [KW-1:0]         cap_idx;

    assign k_next    = k + KW'(1);
    // Load data trails its address by one cycle, so the word arriving now belongs to lane k-1.
    assign cap_idx   = k - KW'(1);
    assign req_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            k         <= '0;
            base      <= '0;
            wr        <= 1'b0;
            wbuf      <= '0;
            mem_sel   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state     <= S_ISSUE;
                        k         <= '0;
                        base      <= req_base;
                        wr        <= req_write;
                        wbuf      <= req_wdata;
                        rsp_rdata <= '0;
                        mem_sel   <= 1'b1;
                        mem_we    <= req_write;
                        mem_addr  <= req_base;
                        mem_wdata <= req_write ? req_wdata[DW-1:0] : '0;
                    end
                end
                S_ISSUE: begin
                    if (!wr && (k != '0)) begin
                        rsp_rdata[cap_idx*DW +: DW] <= mem_rdata;
                    end
                    if (k == LAST) begin
                        mem_sel   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (wr) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_write <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else begin
                        k         <= k_next;
                        mem_addr  <= base + AW'(k_next);
                        mem_wdata <= wr ? wbuf[k_next*DW +: DW] : '0;
                    end
                end
                S_DRAIN: begin
                    rsp_rdata[LAST*DW +: DW] <= mem_rdata;
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_write <= wr;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_write <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_seq.sv
`default_nettype none
// tb_mem_access_seq: directed self-checking bench with a 1-cycle behavioural data memory. Rev 1.0
module tb_mem_access_seq;

    localparam int LANES = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_write = 1'b0;
    logic [AW-1:0]       req_base = '0;
    logic [LANES*DW-1:0] req_wdata = '0;
    logic                mem_sel;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_rdata = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic                rsp_write;
    logic [LANES*DW-1:0] rsp_rdata;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [256];
    int            wcount [256];

    mem_access_seq #(.LANES(LANES), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_base  (req_base),
        .req_wdata (req_wdata),
        .mem_sel   (mem_sel),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata)
    );

    always #5 clk = ~clk;

    // Read-before-write memory; read data appears the cycle after the address is sampled.
    always @(posedge clk) begin
        if (mem_sel) begin
            mem_rdata <= mem[mem_addr[7:0]];
            if (mem_we) begin
                mem[mem_addr[7:0]]    <= mem_wdata;
                wcount[mem_addr[7:0]] <= wcount[mem_addr[7:0]] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic write, input logic [AW-1:0] b,
                          input logic [LANES*DW-1:0] wd, input logic [LANES*DW-1:0] exp_rd,
                          input int bp, input int drop_k, input string name);
        int guard;
        logic [DW-1:0] exp_wd;
        logic [AW-1:0] exp_a;
        guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s req_ready_before: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_write = write;
        req_base  = b;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_base  = '0;
        req_wdata = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k == drop_k) begin
                req_valid = 1'b1;
                req_base  = 32'h0000_0055;
            end else begin
                req_valid = 1'b0;
            end
            exp_a  = b + AW'(k);
            exp_wd = write ? wd[k*DW +: DW] : '0;
            checks++;
            if ({mem_sel, mem_we, mem_addr, mem_wdata} !== {1'b1, write, exp_a, exp_wd}) begin
                failures++;
                $display("FAIL %s access%0d: got sel=%b we=%b addr=%h wd=%h want sel=1 we=%b addr=%h wd=%h",
                         name, k, mem_sel, mem_we, mem_addr, mem_wdata, write, exp_a, exp_wd);
            end
            checks++;
            if ({req_ready, rsp_valid} !== 2'b00) begin
                failures++;
                $display("FAIL %s busy%0d: got req_ready=%b rsp_valid=%b want 0 0",
                         name, k, req_ready, rsp_valid);
            end
            tick();
        end
        req_valid = 1'b0;
        req_base  = '0;
        if (!write) begin
            checks++;
            if ({rsp_valid, mem_sel, mem_we} !== 3'b000) begin
                failures++;
                $display("FAIL %s drain: got rsp_valid=%b sel=%b we=%b want 0 0 0",
                         name, rsp_valid, mem_sel, mem_we);
            end
            tick();
        end
        checks++;
        if ({rsp_valid, rsp_write, mem_sel, req_ready} !== {1'b1, write, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL %s resp_flags: got valid=%b write=%b sel=%b req_ready=%b want 1 %b 0 0",
                     name, rsp_valid, rsp_write, mem_sel, req_ready, write);
        end
        checks++;
        if (rsp_rdata !== exp_rd) begin
            failures++;
            $display("FAIL %s resp_rdata: got %h want %h", name, rsp_rdata, exp_rd);
        end
        for (int i = 0; i < bp; i++) begin
            tick();
            checks++;
            if ({rsp_valid, rsp_write, req_ready, rsp_rdata} !== {1'b1, write, 1'b0, exp_rd}) begin
                failures++;
                $display("FAIL %s backpressure%0d: got valid=%b write=%b req_ready=%b rdata=%h want 1 %b 0 %h",
                         name, i, rsp_valid, rsp_write, req_ready, rsp_rdata, write, exp_rd);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL %s after_handshake: got rsp_valid=%b req_ready=%b want 0 1",
                     name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({req_ready, mem_sel, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_write, rsp_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_values: got req_ready=%b sel=%b we=%b addr=%h wd=%h valid=%b write=%b rdata=%h want all 0",
                     req_ready, mem_sel, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_write, rsp_rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_store();
        do_req(1'b1, 32'd8, {32'd6, 32'd5, 32'd4, 32'd3}, '0, 0, -1, "store");
    endtask

    task automatic test_load_backpressure();
        do_req(1'b0, 32'd8, '0, {32'd6, 32'd5, 32'd4, 32'd3}, 3, -1, "load_bp");
    endtask

    task automatic test_busy_drop();
        do_req(1'b1, 32'h20, {32'hD4, 32'hC3, 32'hB2, 32'hA1}, '0, 0, 1, "busy_store");
        do_req(1'b0, 32'h20, '0, {32'hD4, 32'hC3, 32'hB2, 32'hA1}, 0, 2, "busy_load");
    endtask

    task automatic test_wrap();
        do_req(1'b1, 32'hFFFF_FFFE, {32'h44, 32'h33, 32'h22, 32'h11}, '0, 0, -1, "wrap_store");
        do_req(1'b0, 32'hFFFF_FFFE, '0, {32'h44, 32'h33, 32'h22, 32'h11}, 0, -1, "wrap_load");
    endtask

    task automatic test_reset_mid_store();
        int c8, c9, c10, c11;
        c8  = wcount[8];
        c9  = wcount[9];
        c10 = wcount[10];
        c11 = wcount[11];
        req_valid = 1'b1;
        req_write = 1'b1;
        req_base  = 32'd8;
        req_wdata = {32'hEE, 32'hDD, 32'h22, 32'h11};
        tick();
        req_valid = 1'b0;
        checks++;
        if ({mem_sel, mem_we, mem_addr} !== {2'b11, 32'd8}) begin
            failures++;
            $display("FAIL rst_mid first_access: got sel=%b we=%b addr=%h want 1 1 8", mem_sel, mem_we, mem_addr);
        end
        tick();
        checks++;
        if ({mem_sel, mem_we, mem_addr} !== {2'b11, 32'd9}) begin
            failures++;
            $display("FAIL rst_mid second_access: got sel=%b we=%b addr=%h want 1 1 9", mem_sel, mem_we, mem_addr);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({req_ready, mem_sel, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_write, rsp_rdata} !== '0) begin
            failures++;
            $display("FAIL rst_mid outputs: got req_ready=%b sel=%b we=%b addr=%h wd=%h valid=%b write=%b rdata=%h want all 0",
                     req_ready, mem_sel, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_write, rsp_rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL rst_mid release: got req_ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
        end
        checks++;
        if ({wcount[8] - c8, wcount[9] - c9, wcount[10] - c10, wcount[11] - c11} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL rst_mid write_counts: got %0d %0d %0d %0d want 1 1 0 0",
                     wcount[8] - c8, wcount[9] - c9, wcount[10] - c10, wcount[11] - c11);
        end
        do_req(1'b0, 32'd8, '0, {32'd6, 32'd5, 32'h22, 32'h11}, 0, -1, "rst_mid_load");
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_backpressure();
        test_busy_drop();
        test_wrap();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_access_seq.md
# mem_access_seq

Load/store sequencer that acts as the initiator of the MEM-stage data-memory port. It accepts one vector memory request from the execute side and expands it into LANES consecutive word accesses. For each access it drives the MEM stage's select, write-enable, address and write-data inputs, and for reads it collects the returned words into a lane buffer. When the request is complete it returns a single response to the writeback side over a valid/ready handshake.

## Interface
- LANES, 4, words per request (≥2)
- AW, 32, address width
- DW, 32, data word width

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE and rst low
- req_write  in  1  1 = store, 0 = load
- req_base  in  AW  word address of lane 0
- req_wdata  in  LANES*DW  store data; lane k in bits [k*DW +: DW]
- mem_sel  out  1  access strobe to MEM stage (SelectMem)
- mem_we  out  1  write enable to MEM stage; never high without mem_sel
- mem_addr  out  AW  access address (ALU result path)
- mem_wdata  out  DW  store word
- mem_rdata  in  DW  load word from MEM stage
- rsp_valid  out  1  response present
- rsp_ready  in  1  writeback accepts response
- rsp_write  out  1  response belongs to a store
- rsp_rdata  out  LANES*DW  loaded words, same lane packing as req_wdata

## Operation
- Handshake: a request is accepted on an edge where req_valid & req_ready. base, write flag and wdata are latched at that edge. The buffer is cleared to 0 at that edge.
- States:
  - IDLE: all mem_* outputs are 0. Accept a request → ISSUE.
  - ISSUE: index k runs 0..LANES-1, one access per cycle. mem_sel=1, mem_addr=base+k mod 2^AW, mem_we=write flag, mem_wdata=lane k (0 on loads). After k=LANES-1: a store → RESP; a load → DRAIN.
  - DRAIN: mem_sel=0. This state captures the final load word. → RESP.
  - RESP: rsp_valid=1, rsp_write=latched flag, rsp_rdata=buffer. Holds until rsp_ready, then → IDLE.
- Memory contract: the MEM stage samples address and write data on the rising edge. Stores commit at that edge. Load data for the address sampled at an edge appears on mem_rdata in the following cycle. The sequencer captures that word into its lane at the end of that cycle.
- Stores leave rsp_rdata at 0.
- req_valid while not in IDLE is ignored. There is no queueing.
- Reset: while rst is high, the next state is IDLE, regardless of current state.
  - Reset values: req_ready=0 (1 from the first cycle after rst falls), mem_sel=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_write=0, rsp_rdata=0.
  - Stores already committed before reset are not rolled back. No response is issued for an aborted request.

## Timing
- Acceptance edge = E0.
- Store: accesses are presented in cycles E0–E1 … E(LANES-1)–E(LANES). The last write commits at E(LANES). rsp_valid rises after E(LANES).
- Load: the same access window. The lane k word is captured at E(k+2). rsp_valid rises after E(LANES+1).
- After the response handshake edge there is one IDLE cycle, with req_ready high, before the next request can be accepted. Minimum request period is LANES+2 cycles for a store and LANES+3 for a load (with rsp_ready held high).
- rsp_rdata and rsp_write are stable while rsp_valid is high.
- Address wrap: base+k is computed modulo 2^AW. No error is raised.

## Test plan
- Store, LANES=4: base=8, wdata lanes {3,4,5,6} → four consecutive cycles of mem_sel=1, mem_we=1, addr 8,9,10,11, wdata 3,4,5,6. rsp_valid=1 and rsp_write=1 after E4. rsp_rdata=0.
- Load after the store, with a behavioural 1-cycle memory: base=8 → addr 8..11 with mem_we=0. rsp_rdata lanes {3,4,5,6}. rsp_valid after E5.
- Backpressure: rsp_ready held low for 3 cycles during RESP → rsp_valid stays 1, rsp_rdata is unchanged, req_ready stays 0. Raising rsp_ready completes the handshake, and req_ready=1 in the next cycle.
- Wrap: load with base=0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. Data is placed in lanes 0..3 in that order.
- Reset mid-store: assert rst for one cycle after two words are written (addr 8,9) → all outputs take reset values. Addresses 10 and 11 are not written. No rsp_valid is issued. A new request is accepted in the first cycle after rst is released.
- Busy drop: pulse req_valid with a different base during ISSUE → it is ignored. The addresses of the in-flight request are unaffected.
